// File: rtl/controle_exibe_sequencia.sv
// ============================================================================
// Module   : controle_exibe_sequencia
// Brief    : Plays the stored colour sequence (RAM 0..rodada) on the LEDs,
//            T_ON cycles lit then T_OFF cycles dark per value, then pulses pronto.
//            Optional macro EXIBE_PAUSA_INICIAL_EN: T_OFF-cycle dark pause before
//            the first value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_exibe_sequencia #(
   parameter int T_ON  = 500,
   parameter int T_OFF = 250,
   parameter int TW    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] rodada,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      PREPARA = 4'd1,
      LE      = 4'd2,
      MOSTRA  = 4'd3,
      APAGA   = 4'd4,
      FIM     = 4'd5
   } estado_t;

   localparam logic [TW-1:0] c_ON_LAST  = TW'(T_ON - 1);
   localparam logic [TW-1:0] c_OFF_LAST = TW'(T_OFF - 1);
   localparam logic [TW-1:0] c_UM       = TW'(1);

   estado_t       r_estado;
   estado_t       w_proximo;
   logic [TW-1:0] r_timer;
   logic [3:0]    r_rodada;
   logic [3:0]    r_leds;
   logic [3:0]    r_endereco;
   logic          w_on_fim;
   logic          w_off_fim;
   logic          w_ultimo;

   assign w_on_fim  = (r_timer == c_ON_LAST);
   assign w_off_fim = (r_timer == c_OFF_LAST);
   assign w_ultimo  = (r_endereco == r_rodada);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_estado <= INICIAL;
      else        r_estado <= w_proximo;
   end

   always_comb begin
      w_proximo = INICIAL;
      case (r_estado)
         INICIAL: w_proximo = iniciar ? PREPARA : INICIAL;
`ifdef EXIBE_PAUSA_INICIAL_EN
         PREPARA: w_proximo = w_off_fim ? LE : PREPARA;
`else
         PREPARA: w_proximo = LE;
`endif
         LE:      w_proximo = MOSTRA;
         MOSTRA:  w_proximo = w_on_fim ? APAGA : MOSTRA;
         APAGA:   w_proximo = w_off_fim ? (w_ultimo ? FIM : LE) : APAGA;
         FIM:     w_proximo = INICIAL;
         default: w_proximo = INICIAL;
      endcase
   end

   // LE latches the RAM word; the LED register is cleared when MOSTRA ends so
   // LE, APAGA and the gaps between values stay dark.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_timer    <= '0;
         r_rodada   <= '0;
         r_leds     <= '0;
         r_endereco <= '0;
      end else begin
         case (r_estado)
            INICIAL: begin
               if (iniciar) r_rodada <= rodada;
            end
            PREPARA: begin
               r_endereco <= '0;
`ifdef EXIBE_PAUSA_INICIAL_EN
               r_timer    <= w_off_fim ? '0 : r_timer + c_UM;
`else
               r_timer    <= '0;
`endif
            end
            LE: begin
               r_leds  <= dado_memoria;
               r_timer <= '0;
            end
            MOSTRA: begin
               if (w_on_fim) begin
                  r_timer <= '0;
                  r_leds  <= '0;
               end else begin
                  r_timer <= r_timer + c_UM;
               end
            end
            APAGA: begin
               if (w_off_fim) begin
                  r_timer <= '0;
                  if (!w_ultimo) r_endereco <= r_endereco + 4'd1;
               end else begin
                  r_timer <= r_timer + c_UM;
               end
            end
            default: ;
         endcase
      end
   end

   assign endereco  = r_endereco;
   assign leds      = r_leds;
   assign ocupado   = (r_estado != INICIAL);
   assign pronto    = (r_estado == FIM);
   assign db_estado = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_controle_exibe_sequencia.sv
// ============================================================================
// Module   : tb_controle_exibe_sequencia
// Brief    : Scoreboard bench: each accepted start pushes the expected per-cycle
//            timeline; a negedge monitor pops and compares it against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_exibe_sequencia;

   localparam int T_ON = 2;
`ifdef EXIBE_PAUSA_INICIAL_EN
   localparam int T_OFF = 3;
   localparam int PREP  = T_OFF;
`else
   localparam int T_OFF = 1;
   localparam int PREP  = 1;
`endif
   localparam int TW = 16;

   typedef struct packed {
      logic [3:0] leds;
      logic [3:0] endereco;
      logic [3:0] estado;
      logic       ocupado;
      logic       pronto;
   } obs_t;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] rodada;
   logic [3:0] dado_memoria;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;

   logic [3:0] ram [16];
   obs_t       exp_q [$];
   logic [3:0] model_end;
   logic [3:0] idle_end;
   bit         mon_en;
   int         n_checks;
   int         n_pass;
   obs_t       got;
   obs_t       e;

   controle_exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TW(TW)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .rodada       (rodada),
      .dado_memoria (dado_memoria),
      .endereco     (endereco),
      .leds         (leds),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   // Read data settles within the LE cycle that follows an address change.
   assign dado_memoria = ram[endereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input obs_t g, input obs_t x);
      n_checks++;
      if (g === x) n_pass++;
      else $display("FAIL %s @%0t: got leds=%h endereco=%h estado=%h ocupado=%b pronto=%b, required leds=%h endereco=%h estado=%h ocupado=%b pronto=%b",
                    nm, $time, g.leds, g.endereco, g.estado, g.ocupado, g.pronto,
                    x.leds, x.endereco, x.estado, x.ocupado, x.pronto);
   endtask

   function automatic obs_t mk(input logic [3:0] l, input logic [3:0] a,
                               input logic [3:0] s, input logic o, input logic p);
      mk = '{leds: l, endereco: a, estado: s, ocupado: o, pronto: p};
   endfunction

   // Expected timeline for one accepted start, one entry per cycle.
   function automatic int push_playback(input logic [3:0] r);
      int n = 0;
      for (int p = 0; p < PREP; p++) begin
         exp_q.push_back(mk(4'h0, (p == 0) ? model_end : 4'h0, 4'd1, 1'b1, 1'b0));
         n++;
      end
      for (int i = 0; i <= int'(r); i++) begin
         exp_q.push_back(mk(4'h0, 4'(i), 4'd2, 1'b1, 1'b0));
         n++;
         for (int t = 0; t < T_ON; t++) begin
            exp_q.push_back(mk(ram[i], 4'(i), 4'd3, 1'b1, 1'b0));
            n++;
         end
         for (int t = 0; t < T_OFF; t++) begin
            exp_q.push_back(mk(4'h0, 4'(i), 4'd4, 1'b1, 1'b0));
            n++;
         end
      end
      exp_q.push_back(mk(4'h0, r, 4'd5, 1'b1, 1'b0 | 1'b1));
      n++;
      model_end = r;
      return n;
   endfunction

   always @(negedge clock) begin
      if (mon_en) begin
         got = '{leds: leds, endereco: endereco, estado: db_estado,
                 ocupado: ocupado, pronto: pronto};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            idle_end = e.endereco;
            check("playback", got, e);
         end else begin
            check("idle", got, mk(4'h0, idle_end, 4'd0, 1'b0, 1'b0));
         end
      end
   end

   // Called right after a rising edge with the DUT idle (or in the INICIAL
   // cycle of a chained restart). Returns in the idle cycle after FIM, or in
   // the next INICIAL cycle with iniciar still high when chaining.
   task automatic run(input logic [3:0] r, input bit noise, input bit chain);
      int len;
      iniciar = 1'b1;
      rodada  = r;
      @(posedge clock); #1;
      len = push_playback(r);
      if (!chain) iniciar = 1'b0;
      for (int c = 1; c < len; c++) begin
         @(posedge clock); #1;
         if (noise) begin
            iniciar = 1'($urandom);
            rodada  = 4'($urandom);
         end
      end
      if (!chain) iniciar = 1'b0;
      @(posedge clock); #1;
      if (chain) exp_q.push_back(mk(4'h0, r, 4'd0, 1'b0, 1'b0));
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++)
         ram[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
   endtask

   task automatic reset_mid(input logic [3:0] r);
      int len;
      fill_random();
      ram[0]  = 4'hA;
      iniciar = 1'b1;
      rodada  = r;
      @(posedge clock); #1;
      len = push_playback(r);
      iniciar = 1'b0;
      repeat (PREP + 1) @(posedge clock);
      @(negedge clock); #1;
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check("reset_mid", '{leds: leds, endereco: endereco, estado: db_estado,
                           ocupado: ocupado, pronto: pronto},
            mk(4'h0, 4'h0, 4'd0, 1'b0, 1'b0));
      exp_q.delete();
      model_end = 4'h0;
      idle_end  = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (6) @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      mon_en    = 1'b0;
      model_end = 4'h0;
      idle_end  = 4'h0;
      reset     = 1'b0;
      iniciar   = 1'b0;
      rodada    = 4'h0;
      for (int i = 0; i < 16; i++) ram[i] = 4'h0;
      #2;
      check("reset_values", '{leds: leds, endereco: endereco, estado: db_estado,
                              ocupado: ocupado, pronto: pronto},
            mk(4'h0, 4'h0, 4'd0, 1'b0, 1'b0));
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      ram[0] = 4'h3;
      run(4'd0, 1'b0, 1'b0);

      ram[0] = 4'h1; ram[1] = 4'h2; ram[2] = 4'h4;
      run(4'd2, 1'b0, 1'b0);

      fill_random();
      run(4'd3, 1'b1, 1'b0);

      for (int i = 0; i < 16; i++) ram[i] = 4'(i);
      run(4'd15, 1'b0, 1'b0);

      fill_random();
      run(4'd1, 1'b0, 1'b1);
      fill_random();
      run(4'd3, 1'b0, 1'b0);

      reset_mid(4'd2);

      for (int k = 0; k < 8; k++) begin
         fill_random();
         run(4'($urandom_range(0, 15)), 1'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
      end

      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
